// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the radix-4 multiply-accumulate and SRT divider datapath.
// Holds the sequencer state encoding and the digit geometry.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_ADD  = 2'd2
    } state_t;

    localparam int DIGIT_BITS = 2;

    // Radix-4 digit count for an operand width; the divider uses the same iteration count.
    function automatic int radix4_digits(input int width);
        return width / DIGIT_BITS;
    endfunction

endpackage

// File: rtl/radix4_multiple.sv
// Combinational digit multiple d*B for a radix-4 digit d in 0..3.
// The result is WIDTH+2 bits wide so that 3*B never overflows.
module radix4_multiple
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [DIGIT_BITS-1:0] d,
    input  logic [WIDTH-1:0]      B,
    output logic [WIDTH+1:0]      M
);

    logic [WIDTH+1:0] b_ext;

    assign b_ext = {2'b00, B};

    always_comb begin
        M = '0;
        case (d)
            2'd0: M = '0;
            2'd1: M = b_ext;
            2'd2: M = b_ext << 1;
            2'd3: M = (b_ext << 1) + b_ext;
            default: M = '0;
        endcase
    end

endmodule

// File: rtl/radix4_mac.sv
// Sequential radix-4 multiply-accumulate: P = A*B + C, two multiplier bits per cycle, MSB digit first.
// A result takes WIDTH/2 digit cycles plus one cycle for the final addend.
module radix4_mac
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   C,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    localparam int DIGITS = radix4_digits(WIDTH);
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       a_reg, b_reg, c_reg;
    logic [2*WIDTH-1:0]     acc_reg, p_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   done_reg;

    logic [DIGIT_BITS-1:0]  digit_arr [DIGITS];
    logic [DIGIT_BITS-1:0]  digit;
    logic [WIDTH+1:0]       multiple;
    logic [2*WIDTH-1:0]     acc_next;

    // Digit i is taken from the top of A downwards, so digit 0 is the most significant.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = a_reg[WIDTH-1-DIGIT_BITS*gi -: DIGIT_BITS];
        end
    endgenerate

    assign digit = digit_arr[cnt_reg];

    radix4_multiple #(
        .WIDTH (WIDTH)
    ) u_multiple (
        .d (digit),
        .B (b_reg),
        .M (multiple)
    );

    assign acc_next = {acc_reg[2*WIDTH-3:0], 2'b00} + {{(WIDTH-2){1'b0}}, multiple};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (cnt_reg == LAST_CNT) state_next = ST_ADD;
            ST_ADD:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            p_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        c_reg   <= C;
                        acc_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                ST_CALC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                ST_ADD: begin
                    // Worst case (2^W-1)^2 + (2^W-1) still fits in 2*WIDTH bits.
                    p_reg    <= acc_reg + {{WIDTH{1'b0}}, c_reg};
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign P    = p_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_radix4_mac.sv
// Randomised and directed bench for radix4_mac with a queue-based scoreboard.
// Expected results come from plain integer arithmetic A*B+C and a done-cycle schedule.
module tb_radix4_mac;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     a = '0, b = '0, c = '0;
    logic [2*W-1:0]   p;
    logic             busy, done;

    int unsigned      cyc = 0;
    int               pass_cnt = 0;
    int               total_cnt = 0;

    typedef struct {
        logic [2*W-1:0] p;
        int unsigned    due;
    } exp_t;

    exp_t             sb_q[$];
    logic [2*W-1:0]   last_exp = '0;

    radix4_mac #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .A      (a),
        .B      (b),
        .C      (c),
        .P      (p),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = sb_q.pop_front();
                check("P", p, e.p);
                check("done_cycle", cyc, e.due);
                check("busy_at_done", busy, 0);
                $display("op done: P=%0d expected=%0d cycle=%0d", p, e.p, cyc);
            end
        end
    end

    function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] ia, ib, ic);
        int unsigned r;
        r = int'(ia) * int'(ib) + int'(ic);
        return r[2*W-1:0];
    endfunction

    // Issue one operation from IDLE; returns at the negedge following the accepting edge.
    task automatic issue(input logic [W-1:0] ia, ib, ic);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; c = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e.p = ref_mac(ia, ib, ic);
        e.due = cyc + 5;
        last_exp = e.p;
        sb_q.push_back(e);
        $display("issue: A=%0d B=%0d C=%0d expect P=%0d", ia, ib, ic, e.p);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            check("busy_high", busy, 1);
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;

        // Reset held with start asserted.
        start = 1'b1; a = 8'd9; b = 8'd9; c = 8'd9;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_P", p, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        resetn = 1'b1;
        start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_no_done", done, 0);
        end

        // Basic case, then P must hold.
        issue(8'd13, 8'd15, 8'd5);
        wait_done(10);
        repeat (3) begin
            @(negedge clk);
            check("P_hold", p, last_exp);
        end

        // Extremes.
        issue(8'd255, 8'd255, 8'd255); wait_done(10);
        issue(8'd0,   8'd255, 8'd7);   wait_done(10);
        issue(8'd255, 8'd1,   8'd0);   wait_done(10);

        // Random operations.
        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_done(10);
        end

        // Start during CALC is ignored: one done with the first result only.
        issue(8'd21, 8'd34, 8'd55);
        @(negedge clk);
        a = 8'd200; b = 8'd100; c = 8'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(10);
        repeat (10) begin
            @(negedge clk);
            check("no_second_done", done, 0);
        end

        // Back-to-back with start held: the second start is taken at the first edge
        // seen in IDLE, which is the edge ending the done cycle (E0+6), so done at E0+11.
        @(negedge clk);
        a = 8'd3; b = 8'd4; c = 8'd1; start = 1'b1;
        @(negedge clk);
        e.p = ref_mac(8'd3, 8'd4, 8'd1); e.due = cyc + 5; sb_q.push_back(e);
        $display("issue: A=3 B=4 C=1 expect P=%0d (start held)", e.p);
        a = 8'd10; b = 8'd10; c = 8'd0;
        repeat (5) @(negedge clk);
        e.p = ref_mac(8'd10, 8'd10, 8'd0); e.due = cyc + 6; sb_q.push_back(e);
        $display("issue: A=10 B=10 C=0 expect P=%0d (start held)", e.p);
        @(negedge clk);
        start = 1'b0;
        wait_done(10);
        @(negedge clk);

        // Asynchronous reset mid-operation, between edges after E0+3.
        issue(8'd77, 8'd88, 8'd99);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midreset_P", p, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        sb_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_no_done", done, 0);
        end
        issue(8'd123, 8'd45, 8'd67);
        wait_done(10);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
